// File: rtl/pwm_pkg.sv
//==============================================================================
// Module      : pwm_pkg
// Description : Shared definitions for the multi-channel PWM block: default
//               parameter values, the per-cycle button action encoding and a
//               clog2 helper that never returns less than one bit.
// Config      : PWM_DEBOUNCE_EN (consumed by pwm_button, not by this package)
// Revision    : 1.0 - initial release
//==============================================================================
`default_nettype none

package pwm_pkg;

  localparam int c_def_channels        = 4;
  localparam int c_def_cnt_width       = 8;
  localparam int c_def_duty_step       = 16;
  localparam int c_def_debounce_cycles = 50000;

  // Duty adjustment requested in a given cycle; opposing presses cancel.
  typedef enum logic [1:0] {
    NONE = 2'd0,
    INC  = 2'd1,
    DEC  = 2'd2
  } btn_action_e;

  // Bits needed to index 'value' entries; at least 1 so ports never vanish.
  function automatic int clog2(input int value);
    int width;
    width = 1;
    while ((1 << width) < value) width = width + 1;
    return width;
  endfunction

endpackage

`default_nettype wire

// File: rtl/pwm_button.sv
//==============================================================================
// Module      : pwm_button
// Description : Active-low push-button front end. Two-flop synchroniser
//               followed by either a plain falling-edge detector or, when
//               PWM_DEBOUNCE_EN is defined, a stable-level debounce filter.
//               Emits a one-cycle press pulse per press.
// Ports       : clk    - system clock, rising edge
//               rst    - asynchronous active-high reset
//               button - raw asynchronous button, active low
//               press  - one-cycle pulse per recognised press
// Config      : PWM_DEBOUNCE_EN - enables the DEBOUNCE_CYCLES filter
// Revision    : 1.0 - initial release
//==============================================================================
`default_nettype none

module pwm_button
  import pwm_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = c_def_debounce_cycles
) (
  input  logic clk,
  input  logic rst,
  input  logic button,
  output logic press
);

  logic r_sync1;
  logic r_sync2;

  // Synchroniser resets to the released (high) level.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_sync1 <= 1'b1;
      r_sync2 <= 1'b1;
    end else begin
      r_sync1 <= button;
      r_sync2 <= r_sync1;
    end
  end

`ifdef PWM_DEBOUNCE_EN
  localparam int                c_db_w    = clog2(DEBOUNCE_CYCLES);
  localparam logic [c_db_w-1:0] c_db_last = c_db_w'(DEBOUNCE_CYCLES - 1);

  logic [c_db_w-1:0] r_db_cnt;
  logic              r_db_level;
  logic              r_press;

  // The accepted level starts as "pressed" so a button held through reset
  // must first be seen released for the full filter time before it can fire.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_db_cnt   <= '0;
      r_db_level <= 1'b0;
      r_press    <= 1'b0;
    end else begin
      r_press <= 1'b0;
      if (r_sync2 == r_db_level) begin
        r_db_cnt <= '0;
      end else if (r_db_cnt == c_db_last) begin
        r_db_cnt   <= '0;
        r_db_level <= r_sync2;
        r_press    <= ~r_sync2;
      end else begin
        r_db_cnt <= r_db_cnt + 1'b1;
      end
    end
  end

  assign press = r_press;
`else
  logic [1:0] r_live;
  logic       r_prev;

  // r_live marks when r_sync2 carries a real sample rather than its reset
  // value. Until then r_prev is forced low, so a button already held low at
  // reset release never looks like a fresh high-to-low transition.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_live <= 2'b00;
      r_prev <= 1'b0;
    end else begin
      r_live <= {r_live[0], 1'b1};
      r_prev <= r_live[1] ? r_sync2 : 1'b0;
    end
  end

  assign press = r_live[1] & r_prev & ~r_sync2;

  // DEBOUNCE_CYCLES has no effect in this build; nothing is generated from it.
  if (DEBOUNCE_CYCLES < 1) begin : g_no_debounce
  end
`endif

endmodule

`default_nettype wire

// File: rtl/pwm_multi.sv
//==============================================================================
// Module      : pwm_multi
// Description : CHANNELS independent PWM outputs sharing one free-running
//               counter (period MAX = 2^CNT_WIDTH-1 cycles). Three buttons
//               raise/lower the selected channel's duty in DUTY_STEP units
//               (saturating) and advance the selected channel. New duties take
//               effect only at the start of a period.
// Ports       : clk        - system clock, rising edge
//               rst        - asynchronous active-high reset
//               button_inc - active-low, raise selected duty
//               button_dec - active-low, lower selected duty
//               button_sel - active-low, advance selected channel
//               pwm_out    - registered PWM waveform per channel
//               sel_ch     - currently selected channel index
// Config      : PWM_DEBOUNCE_EN - debounce buttons for DEBOUNCE_CYCLES cycles
// Revision    : 1.0 - initial release
//==============================================================================
`default_nettype none

module pwm_multi
  import pwm_pkg::*;
#(
  parameter int CHANNELS        = c_def_channels,
  parameter int CNT_WIDTH       = c_def_cnt_width,
  parameter int DUTY_STEP       = c_def_duty_step,
  parameter int DEBOUNCE_CYCLES = c_def_debounce_cycles
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         button_inc,
  input  logic                         button_dec,
  input  logic                         button_sel,
  output logic [CHANNELS-1:0]          pwm_out,
  output logic [clog2(CHANNELS)-1:0]   sel_ch
);

  localparam int                   c_sel_w    = clog2(CHANNELS);
  localparam logic [c_sel_w-1:0]   c_sel_last = c_sel_w'(CHANNELS - 1);
  localparam logic [CNT_WIDTH-1:0] c_max      = CNT_WIDTH'((1 << CNT_WIDTH) - 1);
  localparam logic [CNT_WIDTH-1:0] c_last     = CNT_WIDTH'((1 << CNT_WIDTH) - 2);
  // One extra bit so the increment can be compared against MAX before it wraps.
  localparam logic [CNT_WIDTH:0]   c_step     = (CNT_WIDTH + 1)'(DUTY_STEP);

  logic               w_press_inc;
  logic               w_press_dec;
  logic               w_press_sel;
  btn_action_e        w_action;
  logic               w_wrap;
  logic [CNT_WIDTH-1:0] r_cnt;
  logic [c_sel_w-1:0] r_sel;

  pwm_button #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_btn_inc (
    .clk    (clk),
    .rst    (rst),
    .button (button_inc),
    .press  (w_press_inc)
  );

  pwm_button #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_btn_dec (
    .clk    (clk),
    .rst    (rst),
    .button (button_dec),
    .press  (w_press_dec)
  );

  pwm_button #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_btn_sel (
    .clk    (clk),
    .rst    (rst),
    .button (button_sel),
    .press  (w_press_sel)
  );

  always_comb begin
    w_action = NONE;
    if (w_press_inc && !w_press_dec) begin
      w_action = INC;
    end else if (w_press_dec && !w_press_inc) begin
      w_action = DEC;
    end
  end

  // Counter runs 0..MAX-1; w_wrap is true in the last cycle of each period.
  assign w_wrap = (r_cnt == c_last);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_cnt <= '0;
    end else if (w_wrap) begin
      r_cnt <= '0;
    end else begin
      r_cnt <= r_cnt + 1'b1;
    end
  end

  // Duty updates below use the pre-advance r_sel, so a sel press coinciding
  // with inc/dec acts on the old channel before moving on.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_sel <= '0;
    end else if (w_press_sel) begin
      r_sel <= (r_sel == c_sel_last) ? '0 : r_sel + 1'b1;
    end
  end

  assign sel_ch = r_sel;

  for (genvar i = 0; i < CHANNELS; i++) begin : g_ch
    logic [CNT_WIDTH:0]   w_sum;
    logic [CNT_WIDTH-1:0] w_pend_nxt;
    logic [CNT_WIDTH-1:0] r_pend;
    logic [CNT_WIDTH-1:0] r_act;
    logic                 r_pwm;

    always_comb begin
      w_sum      = {1'b0, r_pend} + c_step;
      w_pend_nxt = r_pend;
      if (r_sel == c_sel_w'(i)) begin
        case (w_action)
          INC:     w_pend_nxt = (w_sum > {1'b0, c_max}) ? c_max : w_sum[CNT_WIDTH-1:0];
          DEC:     w_pend_nxt = ({1'b0, r_pend} < c_step) ? '0
                                : r_pend - c_step[CNT_WIDTH-1:0];
          default: w_pend_nxt = r_pend;
        endcase
      end
    end

    // r_act only changes as the counter returns to 0, so every period is
    // produced entirely with one duty value.
    always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
        r_pend <= '0;
        r_act  <= '0;
        r_pwm  <= 1'b0;
      end else begin
        r_pend <= w_pend_nxt;
        if (w_wrap) begin
          r_act <= r_pend;
        end
        r_pwm <= (r_cnt < r_act);
      end
    end

    assign pwm_out[i] = r_pwm;
  end

endmodule

`default_nettype wire

// File: tb/tb_pwm_multi.sv
//==============================================================================
// Module      : tb_pwm_multi
// Description : Scoreboard bench for pwm_multi with CHANNELS=2, CNT_WIDTH=4
//               (period 15), DUTY_STEP=4, DEBOUNCE_CYCLES=8. The stimulus
//               queues expected pwm_out/sel_ch values tagged with the cycle
//               number since reset release; a monitor compares each entry on
//               the falling edge of that cycle.
// Config      : PWM_DEBOUNCE_EN - adds the glitch / long-press cases
// Revision    : 1.0 - initial release
//==============================================================================
`default_nettype none

module tb_pwm_multi;

  localparam int CH   = 2;
  localparam int CW   = 4;
  localparam int STEP = 4;
  localparam int DB   = 8;
  localparam int PER  = 15;
`ifdef PWM_DEBOUNCE_EN
  localparam int HOLD = DB + 4;
`else
  localparam int HOLD = 4;
`endif

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       button_inc = 1'b1;
  logic       button_dec = 1'b1;
  logic       button_sel = 1'b1;
  logic [1:0] pwm_out;
  logic [0:0] sel_ch;

  pwm_multi #(
    .CHANNELS        (CH),
    .CNT_WIDTH       (CW),
    .DUTY_STEP       (STEP),
    .DEBOUNCE_CYCLES (DB)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .button_inc (button_inc),
    .button_dec (button_dec),
    .button_sel (button_sel),
    .pwm_out    (pwm_out),
    .sel_ch     (sel_ch)
  );

  always #5 clk = ~clk;

  // Rising edges since reset release; equals the DUT counter phase.
  int cyc;
  always @(posedge clk or posedge rst) begin
    if (rst) cyc <= 0;
    else     cyc <= cyc + 1;
  end

  typedef struct {
    int         cyc;
    int         tag;
    logic [1:0] pwm;
    logic       sel;
  } exp_t;

  exp_t sb[$];
  int   checks = 0;
  int   errors = 0;

  // Monitor
  exp_t mon_e;
  always @(negedge clk) begin
    while (sb.size() > 0 && sb[0].cyc <= cyc) begin
      mon_e = sb.pop_front();
      checks++;
      if (mon_e.cyc != cyc) begin
        errors++;
        $display("FAIL tag%0d: entry for cycle %0d reached at cycle %0d", mon_e.tag, mon_e.cyc, cyc);
      end else if (pwm_out !== mon_e.pwm || sel_ch !== mon_e.sel) begin
        errors++;
        $display("FAIL tag%0d cyc%0d: pwm_out=%b sel_ch=%0d, expected pwm_out=%b sel_ch=%0d",
                 mon_e.tag, cyc, pwm_out, sel_ch, mon_e.pwm, mon_e.sel);
      end
    end
  end

  task automatic push_one(input int tag, input int c, input logic [1:0] p, input logic s);
    exp_t e;
    e.cyc = c; e.tag = tag; e.pwm = p; e.sel = s;
    sb.push_back(e);
  endtask

  // Output after edge j reflects counter value (j-1) mod PER against the duty
  // in force; a0/a1 are hand-computed duties for the whole range.
  task automatic push_range(input int tag, input int from, input int to,
                            input int a0, input int a1, input logic s);
    for (int j = from; j <= to; j++) begin
      push_one(tag, j, {logic'(((j - 1) % PER) < a1), logic'(((j - 1) % PER) < a0)}, s);
    end
  endtask

  task automatic drain();
    int n;
    n = 0;
    while (sb.size() > 0) begin
      @(negedge clk);
      n++;
      if (n > 200) begin
        $display("FAIL drain: %0d entries still queued after 200 cycles, expected 0", sb.size());
        $fatal(1);
      end
    end
  endtask

  // Check one full period starting at the next period boundary.
  task automatic window(input int tag, input int a0, input int a1, input logic s);
    int start;
    start = (cyc / PER + 1) * PER + 1;
    push_range(tag, start, start + PER - 1, a0, a1, s);
    drain();
  endtask

  task automatic wait_phase(input int p);
    int n;
    n = 0;
    do begin
      @(negedge clk);
      n++;
      if (n > 2 * PER) begin
        $display("FAIL phase: counter phase %0d not reached, got %0d", p, cyc % PER);
        $fatal(1);
      end
    end while (cyc % PER != p);
  endtask

  task automatic press(input bit i, input bit d, input bit s);
    @(negedge clk);
    button_inc = ~i;
    button_dec = ~d;
    button_sel = ~s;
    repeat (HOLD) @(negedge clk);
    button_inc = 1'b1;
    button_dec = 1'b1;
    button_sel = 1'b1;
    repeat (HOLD) @(negedge clk);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, expected completion");
    $fatal(1);
  end

  initial begin
    int k;
    repeat (3) @(negedge clk);
    push_one(0, 0, 2'b00, 1'b0);
    repeat (2) @(negedge clk);
    rst = 1'b0;
    repeat (2 * HOLD + 4) @(negedge clk);
    window(1, 0, 0, 1'b0);

    press(1, 0, 0);                       // ch0: 0 -> 4
    window(2, 4, 0, 1'b0);
    press(1, 1, 0);                       // cancels
    window(3, 4, 0, 1'b0);

    wait_phase(1);                        // inc mid-period: 4 -> 8 next period
    k = cyc;
    push_range(4, k + 1, k + 14, 4, 0, 1'b0);
    push_range(5, k + 15, k + 29, 8, 0, 1'b0);
    press(1, 0, 0);
    drain();

    press(1, 0, 0);                       // 12
    press(1, 0, 0);                       // 15 (saturated)
    press(1, 0, 0);                       // stays 15
    window(6, 15, 0, 1'b0);

    press(0, 0, 1);                       // sel -> 1
    window(7, 15, 0, 1'b1);
    press(0, 1, 0);                       // ch1 stays 0
    window(8, 15, 0, 1'b1);
    press(1, 0, 0);                       // ch1: 0 -> 4
    window(9, 15, 4, 1'b1);
    press(0, 0, 1);                       // sel wraps -> 0
    window(10, 15, 4, 1'b0);
    press(0, 1, 1);                       // dec on old ch0 (15 -> 11), sel -> 1
    window(11, 11, 4, 1'b1);

    wait_phase(2);                        // next sample: counter 2, both high
    k = cyc;
    push_one(12, k + 1, 2'b11, 1'b1);
    @(negedge clk);
    @(posedge clk);
    #2;
    rst = 1'b1;
    button_inc = 1'b0;                    // held low through reset release
    push_one(13, 0, 2'b00, 1'b0);
    repeat (3) @(negedge clk);
    rst = 1'b0;
    repeat (HOLD + 4) @(negedge clk);
    button_inc = 1'b1;
    repeat (HOLD + 2) @(negedge clk);
    window(14, 0, 0, 1'b0);

    press(1, 0, 0);                       // period phase must restart at 0
    window(15, 4, 0, 1'b0);

`ifdef PWM_DEBOUNCE_EN
    @(negedge clk);
    button_inc = 1'b0;                    // 5-cycle glitch: ignored
    repeat (5) @(negedge clk);
    button_inc = 1'b1;
    repeat (HOLD) @(negedge clk);
    window(16, 4, 0, 1'b0);
    button_inc = 1'b0;                    // 10-cycle press: one inc
    repeat (10) @(negedge clk);
    button_inc = 1'b1;
    repeat (HOLD) @(negedge clk);
    window(17, 8, 0, 1'b0);
`endif

    drain();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/pwm_multi.md
PWM_MULTI -- requirements
Module: pwm_multi

Interface
REQ-001 SHALL have parameter CHANNELS, default 4, number of independent PWM outputs (1..16).
REQ-002 SHALL have parameter CNT_WIDTH, default 8, counter/duty width; MAX = 2^CNT_WIDTH-1.
REQ-003 SHALL have parameter DUTY_STEP, default 16, duty change per button press (1..MAX).
REQ-004 SHALL have parameter DEBOUNCE_CYCLES, default 50000, required stable-low time; used only with PWM_DEBOUNCE_EN.
REQ-005 SHALL have port clk  input  1  single system clock, rising edge.
REQ-006 SHALL have port rst  input  1  reset, asynchronous, active-high.
REQ-007 SHALL have port button_inc  input  1  active-low, asynchronous, raises selected duty.
REQ-008 SHALL have port button_dec  input  1  active-low, asynchronous, lowers selected duty.
REQ-009 SHALL have port button_sel  input  1  active-low, asynchronous, advances selected channel.
REQ-010 SHALL have port pwm_out  output  CHANNELS  one PWM waveform per channel.
REQ-011 SHALL have port sel_ch  output  clog2(CHANNELS) (min 1)  currently selected channel index.

Function
REQ-012 Each button SHALL pass through a 2-flop synchroniser; a press is the synchronised high-to-low transition, one action per press regardless of hold length.
REQ-013 Free-running counter cnt SHALL count 0..MAX-1 and wrap to 0; period = MAX cycles.
REQ-014 pwm_out[i] SHALL be registered, = (cnt < duty_act[i]); duty 0 -> constant low, duty MAX -> constant high.
REQ-015 Press inc SHALL set duty_pend[sel] = min(duty_pend[sel]+DUTY_STEP, MAX); computed at CNT_WIDTH+1 bits, no overflow wrap.
REQ-016 Press dec SHALL set duty_pend[sel] = max(duty_pend[sel]-DUTY_STEP, 0); no underflow wrap.
REQ-017 inc and dec press detected in the same cycle SHALL leave duty unchanged.
REQ-018 Press sel SHALL advance sel_ch by 1, wrapping CHANNELS-1 -> 0.
REQ-019 sel press coinciding with inc/dec SHALL apply inc/dec to the old channel, then advance.
REQ-020 duty_act[i] SHALL load from duty_pend[i] only in the cycle cnt wraps to 0 (glitch-free; no partial periods).
REQ-021 Latency press-to-output SHALL be 2 sync cycles + 1 edge cycle + wait to next period start.
REQ-022 Non-selected channels SHALL be unaffected by any button.

Reset
REQ-023 rst high SHALL immediately clear cnt, all duty_pend/duty_act, sel_ch, synchroniser flops (to 1, released state), debounce counters, and drive pwm_out to all 0.
REQ-024 Reset mid-period SHALL discard pending duty changes; first period after release starts at cnt=0.
REQ-025 Button held low across reset release SHALL NOT generate a press.

Configuration
REQ-026 Macro PWM_DEBOUNCE_EN defined: press SHALL require synchronised input low for DEBOUNCE_CYCLES consecutive cycles; a high sample restarts the count; release similarly debounced before next press.
REQ-027 PWM_DEBOUNCE_EN undefined: press SHALL be the raw synchronised falling edge; DEBOUNCE_CYCLES ignored; no debounce logic synthesised.

Structure
REQ-028 Package pwm_pkg SHALL hold clog2 helper function, default parameter constants, and the button-action enum (NONE, INC, DEC).
REQ-029 Sub-module pwm_button (sync + optional debounce + press pulse) SHALL be instantiated three times.

Verification (CHANNELS=2, CNT_WIDTH=4 -> MAX=15, DUTY_STEP=4, debounce off unless noted)
REQ-030 Assert rst mid-run -> same cycle pwm_out=2'b00, sel_ch=0; after release cnt restarts at 0.
REQ-031 One inc press on ch0 -> from next wrap pwm_out[0] high 4 of 15 cycles, pwm_out[1] stays 0.
REQ-032 Five inc presses on ch0 -> duty 15 (saturated, not 4), pwm_out[0] constant 1.
REQ-033 sel press -> sel_ch=1; dec press -> ch1 duty stays 0; second sel press -> sel_ch wraps to 0.
REQ-034 inc and dec falling edges in same cycle -> duty unchanged; inc mid-period -> current period duty unchanged, new duty from next wrap.
REQ-035 PWM_DEBOUNCE_EN, DEBOUNCE_CYCLES=8: 5-cycle low glitch -> no change; 10-cycle low -> exactly one inc.
